serial_shifter: RTL and testbench
=================================

SERIAL_SHIFTER -- requirements
Module: serial_shifter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the operand and result width; only 32 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port start, input, 1 bit: request strobe, sampled on the rising clk edge.
REQ-005 SHALL have port op, input, 3 bits: 3'b011 = SLL, 3'b100 = SRL, 3'b101 = SRA; all other codes are illegal.
REQ-006 SHALL have port a, input, 32 bits, signed: the operand.
REQ-007 SHALL have port sh_amt, input, 5 bits, unsigned: the shift count, 0..31.
REQ-008 SHALL have port busy, output, 1 bit: high while a request is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port sh_result, output, 32 bits, signed: the shifted value, held until the next accepted start.
REQ-011 SHALL have port op_err, output, 1 bit: qualifies done; high when the accepted op was illegal.

Function
REQ-012 SHALL implement a three-state FSM: IDLE, SHIFT, DONE.
REQ-013 SHALL, in IDLE with start=1, latch op, a and sh_amt into internal registers; these values are the accepted request.
REQ-014 SHALL, on acceptance, go to SHIFT if sh_amt is nonzero and op is legal; otherwise go to DONE.
REQ-015 SHALL, in SHIFT, shift the working register by exactly 1 bit per cycle and decrement the remaining count by 1.
REQ-016 SHALL use these step rules: SLL fills bit 0 with 0; SRL fills bit 31 with 0; SRA fills bit 31 with a copy of bit 31.
REQ-017 SHALL move from SHIFT to DONE on the cycle that the remaining count reaches 0.
REQ-018 SHALL assert done for exactly 1 cycle, exactly sh_amt+1 cycles after the accepting edge; for sh_amt=0 that is 1 cycle.
REQ-019 SHALL update sh_result in the same cycle that done is asserted.
REQ-020 SHALL return from DONE to IDLE unconditionally after 1 cycle.
REQ-021 SHALL drive busy high in SHIFT and in DONE, and low in IDLE.
REQ-022 SHALL ignore start whenever busy=1; no queuing, and the in-flight request is unaffected.
REQ-023 SHALL, for an illegal op, assert done with op_err=1 after 1 cycle and set sh_result equal to a.
REQ-024 SHALL drive op_err=0 for every legal op.
REQ-025 SHALL make the result bit-identical to a combinational << (SLL), >> (SRL) or >>> (SRA) of a by sh_amt.
REQ-026 SHALL have no combinational path from any input to any output.
REQ-027 SHALL NOT produce simulation display or print output.

Reset
REQ-028 SHALL, on rst=1 and regardless of clk, force: state=IDLE, busy=0, done=0, op_err=0, sh_result=0, working register=0, count=0.
REQ-029 SHALL, if rst is asserted mid-request, abandon the request with no done pulse.
REQ-030 SHALL accept a new start on the first clk edge after rst deasserts.

Structure
REQ-031 SHALL place the op encodings (OP_SLL, OP_SRL, OP_SRA) and the FSM state encoding in a shared package, also used by the ALU decode.
REQ-032 SHALL use one sub-module, shift_step: a combinational 1-bit step computed from op and the current register value; the FSM and counters stay in serial_shifter.

Verification
REQ-033 SHALL cover this scenario: SLL, a=32'h0000_0001, sh_amt=4 -> done exactly 5 cycles after start, sh_result=32'h0000_0010, op_err=0.
REQ-034 SHALL cover this scenario: SRA, a=32'h8000_0000, sh_amt=31 -> done after 32 cycles, sh_result=32'hFFFF_FFFF; the same request with SRL -> sh_result=32'h0000_0001.
REQ-035 SHALL cover this scenario: SRL, a=32'hDEAD_BEEF, sh_amt=0 -> done after 1 cycle, sh_result=32'hDEAD_BEEF.
REQ-036 SHALL cover this scenario: op=3'b111, a=32'h1234_5678 -> done after 1 cycle, op_err=1, sh_result=32'h1234_5678.
REQ-037 SHALL cover this scenario: SLL, sh_amt=8; a second start in cycle 3 carrying a different operand; rst pulsed in cycle 5 -> the second start is ignored, no done pulse occurs, all outputs read 0, and a start in the cycle after rst deasserts is accepted.
REQ-038 SHALL cover this scenario: 1000 random legal requests -> every sh_result matches the reference model of REQ-025, and every done arrives at sh_amt+1 cycles.

Source files
------------

// File: rtl/serial_shifter_pkg.sv
// Shared encodings for the serial shifter and the ALU decode.
package serial_shifter_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned CNT_W = 5;

  localparam logic [OP_W-1:0] OP_SLL = 3'b011;
  localparam logic [OP_W-1:0] OP_SRL = 3'b100;
  localparam logic [OP_W-1:0] OP_SRA = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // True for the three shift codes this unit executes.
  function automatic logic op_legal(input logic [OP_W-1:0] code);
    case (code)
      OP_SLL, OP_SRL, OP_SRA: op_legal = 1'b1;
      default:                op_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/serial_shifter_step.sv
// Combinational single-bit shift of the working register.
module shift_step
  import serial_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic [OP_W-1:0]         op,
  input  logic signed [WIDTH-1:0] din,
  output logic signed [WIDTH-1:0] dout
);

  // One-bit step: zero fill for logical shifts, sign copy for SRA.
  always_comb begin
    dout = din;
    case (op)
      OP_SLL:  dout = {din[WIDTH-2:0], 1'b0};
      OP_SRL:  dout = {1'b0, din[WIDTH-1:1]};
      OP_SRA:  dout = {din[WIDTH-1], din[WIDTH-1:1]};
      default: dout = din;
    endcase
  end

endmodule

// File: rtl/serial_shifter.sv
// Multi-cycle barrel-shift replacement: shifts one bit per clock.
module serial_shifter
  import serial_shifter_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [OP_W-1:0]         op,
  input  logic signed [WIDTH-1:0] a,
  input  logic [CNT_W-1:0]        sh_amt,
  output logic                    busy,
  output logic                    done,
  output logic signed [WIDTH-1:0] sh_result,
  output logic                    op_err
);

  state_e                  state_q, state_d;
  logic [OP_W-1:0]         op_q;
  logic signed [WIDTH-1:0] work_q;
  logic signed [WIDTH-1:0] work_step;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [WIDTH-1:0] res_q;
  logic                    err_q;
  logic                    accept;
  logic                    direct_done;

  assign accept      = (state_q == ST_IDLE) && start;
  // Zero counts and illegal codes skip SHIFT and complete with the operand.
  assign direct_done = !op_legal(op) || (sh_amt == '0);

  shift_step #(.WIDTH(WIDTH)) u_step (
    .op  (op_q),
    .din (work_q),
    .dout(work_step)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode; SHIFT exits on the step that takes the count to zero.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = direct_done ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Request capture, per-cycle shifting and result update on entry to DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q   <= '0;
      work_q <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else if (accept) begin
      op_q   <= op;
      work_q <= a;
      cnt_q  <= sh_amt;
      err_q  <= !op_legal(op);
      if (direct_done) res_q <= a;
    end else if (state_q == ST_SHIFT) begin
      work_q <= work_step;
      cnt_q  <= cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) res_q <= work_step;
    end
  end

  // Outputs decode registered state only, so inputs never reach them directly.
  assign busy      = (state_q != ST_IDLE);
  assign done      = (state_q == ST_DONE);
  assign op_err    = done && err_q;
  assign sh_result = res_q;

endmodule

// File: tb/tb_serial_shifter.sv
module tb_serial_shifter;
  import serial_shifter_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               start = 1'b0;
  logic [2:0]         op = 3'b000;
  logic signed [31:0] a = '0;
  logic [4:0]         sh_amt = '0;
  logic               busy, done, op_err;
  logic signed [31:0] sh_result;

  int n_chk = 0;
  int n_fail = 0;

  serial_shifter #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .sh_amt(sh_amt),
    .busy(busy), .done(done), .sh_result(sh_result), .op_err(op_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the combinational shift operators applied to the operand.
  function automatic logic [31:0] ref_shift(input logic [2:0] c, input logic signed [31:0] v,
                                            input logic [4:0] n);
    case (c)
      3'b011:  ref_shift = v << n;
      3'b100:  ref_shift = v >> n;
      3'b101:  ref_shift = v >>> n;
      default: ref_shift = v;
    endcase
  endfunction

  // Issue one request, wait (bounded) for done; optionally fire a stray start while busy.
  task automatic do_req(input logic [2:0] c, input logic [31:0] v, input logic [4:0] n,
                        input bit intrude, output logic [31:0] res, output int lat,
                        output logic err, output logic busy_gap, output logic post_idle);
    bit got;
    @(negedge clk);
    start = 1'b1; op = c; a = v; sh_amt = n;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; got = 0; busy_gap = 1'b0;
    res = 'x; err = 1'bx;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (intrude && lat == 2) begin
        start = 1'b1; op = 3'b100; a = $urandom; sh_amt = 5'd1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        got = 1; res = sh_result; err = op_err;
      end else if (!busy) busy_gap = 1'b1;
    end
    start = 1'b0;
    @(negedge clk);
    post_idle = !busy && !done;
  endtask

  logic [31:0] res;
  int          lat;
  logic        err, gap, idle_ok;
  logic [2:0]  rc;
  logic [31:0] rv;
  logic [4:0]  rn;
  int          rand_bad;
  bit          saw_done;

  initial begin
    // Reset state
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(op_err), 32'd0);
    chk("rst_res", sh_result, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // SLL 1 by 4
    do_req(OP_SLL, 32'h0000_0001, 5'd4, 0, res, lat, err, gap, idle_ok);
    chk("sll4_res", res, 32'h0000_0010);
    chk("sll4_lat", 32'(lat), 32'd5);
    chk("sll4_err", 32'(err), 32'd0);
    chk("sll4_busy", 32'(gap), 32'd0);
    chk("sll4_idle", 32'(idle_ok), 32'd1);
    chk("sll4_hold", sh_result, 32'h0000_0010);

    // SRA / SRL of MSB by 31
    do_req(OP_SRA, 32'h8000_0000, 5'd31, 0, res, lat, err, gap, idle_ok);
    chk("sra31_res", res, 32'hFFFF_FFFF);
    chk("sra31_lat", 32'(lat), 32'd32);
    do_req(OP_SRL, 32'h8000_0000, 5'd31, 0, res, lat, err, gap, idle_ok);
    chk("srl31_res", res, 32'h0000_0001);
    chk("srl31_lat", 32'(lat), 32'd32);

    // Zero shift
    do_req(OP_SRL, 32'hDEAD_BEEF, 5'd0, 0, res, lat, err, gap, idle_ok);
    chk("srl0_res", res, 32'hDEAD_BEEF);
    chk("srl0_lat", 32'(lat), 32'd1);
    chk("srl0_idle", 32'(idle_ok), 32'd1);

    // Illegal op
    do_req(3'b111, 32'h1234_5678, 5'd9, 0, res, lat, err, gap, idle_ok);
    chk("ill_res", res, 32'h1234_5678);
    chk("ill_lat", 32'(lat), 32'd1);
    chk("ill_err", 32'(err), 32'd1);

    // Stray start while busy is ignored
    do_req(OP_SLL, 32'h0000_0001, 5'd6, 1, res, lat, err, gap, idle_ok);
    chk("ign_res", res, 32'h0000_0040);
    chk("ign_lat", 32'(lat), 32'd7);
    chk("ign_idle", 32'(idle_ok), 32'd1);

    // Reset mid-request abandons it; restart right after deassert
    @(negedge clk);
    start = 1'b1; op = OP_SLL; a = 32'h0000_00F0; sh_amt = 5'd8;
    @(posedge clk);
    saw_done = 0;
    for (int cyc = 1; cyc <= 5; cyc++) begin
      @(negedge clk);
      if (done) saw_done = 1;
      if (cyc == 3) begin
        start = 1'b1; op = OP_SRL; a = 32'hFFFF_0000; sh_amt = 5'd1;
      end else begin
        start = 1'b0;
      end
      if (cyc == 5) rst = 1'b1;
    end
    #1;
    chk("rst_mid_nodone", 32'(saw_done), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_done", 32'(done), 32'd0);
    chk("rst_mid_err", 32'(op_err), 32'd0);
    chk("rst_mid_res", sh_result, 32'd0);
    @(negedge clk);
    chk("rst_hold_done", 32'(done), 32'd0);
    rst = 1'b0;
    start = 1'b1; op = OP_SLL; a = 32'h0000_0003; sh_amt = 5'd2;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0; saw_done = 0;
    while (!saw_done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (done) begin saw_done = 1; res = sh_result; end
    end
    chk("post_rst_lat", 32'(lat), 32'd3);
    chk("post_rst_res", res, 32'h0000_000C);

    // Random legal requests
    rand_bad = 0;
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(2, 0))
        0:       rc = OP_SLL;
        1:       rc = OP_SRL;
        default: rc = OP_SRA;
      endcase
      rv = $urandom;
      rn = 5'($urandom_range(31, 0));
      do_req(rc, rv, rn, 0, res, lat, err, gap, idle_ok);
      chk($sformatf("rnd%0d_res", i), res, ref_shift(rc, rv, rn));
      chk($sformatf("rnd%0d_lat", i), 32'(lat), 32'(rn) + 32'd1);
      chk($sformatf("rnd%0d_err", i), 32'(err), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
